serial_addsub_digit: RTL and testbench
======================================

Name: serial_addsub_digit

Overview:
Digit-serial adder/subtractor, the parametrised successor of the bit-serial adder with valid. Consumes DIGIT_W bits of each operand per valid beat, LSB digit first. Supports add or two's-complement subtract per operand, selected on the first beat. Produces a registered sum stream with per-operand carry, signed-overflow and length-error status. Sits between serial operand sources and serial result consumers in the arithmetic datapath.

Parameters:
DIGIT_W, 4, bits of each operand consumed per beat (>=1)
MAX_BEATS, 16, maximum beats per operand (>=1); reaching it without last forces termination

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
vld  input  1  a/b/sub/last valid this cycle
a  input  DIGIT_W  operand A digit
b  input  DIGIT_W  operand B digit
sub  input  1  mode; sampled only on the first beat of an operand (1 = A-B)
last  input  1  final digit of operand; ignored when vld=0
out_vld  output  1  sum digit valid
sum  output  DIGIT_W  result digit
out_last  output  1  final result digit of operand (qualified by out_vld)
carry_out  output  1  final carry with out_last; for subtract 1 = no borrow
overflow  output  1  signed overflow of whole operand, with out_last
len_err  output  1  operand reached MAX_BEATS without last, with out_last

Behaviour:
- Reset (async, immediate): out_vld, sum, out_last, carry_out, overflow, len_err = 0; carry = 0; mode = 0; beat count = 0; state FIRST.
- States: FIRST (awaiting first beat of operand), BUSY (mid-operand).
- Beat = cycle with vld=1. vld=0 cycles: no state, carry, count or mode change; a, b, sub, last are don't-care.
- FIRST beat: mode_eff = sub, carry_in = sub; mode latched. BUSY beat: mode_eff = latched mode, carry_in = stored carry; sub ignored.
- Per beat: {c, s} = a + (b XOR {DIGIT_W{mode_eff}}) + carry_in, width DIGIT_W+1.
- Latency 1: registered out_vld = vld, sum = s on the following cycle. sum holds its last value while out_vld=0; out_last, carry_out, overflow and len_err are 0 whenever out_vld=0.
- Beat count increments per beat. Terminating beat = (last=1) or (count = MAX_BEATS-1 on this beat).
- Terminating beat: out_last=1, carry_out=c, overflow = carry into MSB XOR carry out of MSB of this digit. len_err=1 only if last=0. Next state FIRST; carry and count clear.
- Non-terminating beat: stored carry = c, state BUSY.
- A single-beat operand (last on FIRST) is legal.
- last=1 with vld=0: no effect.
- Reset mid-operand: discards the operand; the next beat is a FIRST beat.

Optional Feature:
SERIAL_ADDSUB_ZERO_FLAG_EN
- Defined: extra output port zero (1 bit). Asserted with out_last when every sum digit of the operand, including the final one, was 0; otherwise 0. Internal accumulator resets with the operand and with rst.
- Undefined: no zero port and no accumulator logic; all other behaviour unchanged.

Test Plan:
1. DIGIT_W=4, add 0x1234+0x0FFF: a digits 4,3,2,1; b digits F,F,F,0; last on 4th beat -> sum 3,3,2,2; out_last on 4th output; carry_out=0; overflow=0; len_err=0.
2. Subtract 0x05-0x07 (2 beats, sub=1 on first beat only, sub=0 on second) -> sum E,F; carry_out=0 (borrow); overflow=0. With ZERO_FLAG_EN, 0x07-0x07 -> sum 0,0; zero=1; carry_out=1.
3. Test 1 repeated with 1-3 idle cycles (vld=0, random a/b/sub, last=1) between beats -> identical sum digits. out_vld only one cycle after each beat. No spurious out_last.
4. Signed overflow, 8-bit add 0x7F+0x01: digits F,7 and 1,0 -> sum 0,8; overflow=1; carry_out=0. Then 0x80+0x80 -> sum 0,0; overflow=1; carry_out=1.
5. MAX_BEATS=4, five beats with last=0, all-zero operands:
   - 4th output: out_last=1, len_err=1.
   - 5th beat is treated as FIRST: sub sampled on it, carry_in=sub.
6. rst asserted asynchronously after 2 beats of an add -> all outputs 0 before the next edge. Next beat with a=1, b=1, sub=0 -> sum 2, carry from the aborted operand not used.

Source files
------------

// File: rtl/serial_addsub_digit.sv
// serial_addsub_digit: digit-serial adder/subtractor, LSB digit first.
// Each valid beat adds one DIGIT_W-bit digit of A and B, or A and ~B when
// subtracting. The result digit and the per-operand status appear one
// cycle later.
// Optional feature: define SERIAL_ADDSUB_ZERO_FLAG_EN to add a 'zero'
// output. It reports an all-zero result together with out_last.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_FIRST | waiting for the first beat of an operand (mode sampled here)
// S_BUSY  | inside an operand; carry and mode come from the previous beat
module serial_addsub_digit #(
  parameter int DIGIT_W   = 4,
  parameter int MAX_BEATS = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vld,
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               sub,
  input  logic               last,
  output logic               out_vld,
  output logic [DIGIT_W-1:0] sum,
  output logic               out_last,
  output logic               carry_out,
  output logic               overflow,
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
  output logic               len_err,
  output logic               zero
`else
  output logic               len_err
`endif
);

  localparam int CNT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BEATS - 1);

  typedef enum logic {S_FIRST, S_BUSY} state_t;

  state_t             state_q, state_d;
  logic               mode_q, mode_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               first_beat;
  logic               mode_eff;
  logic               carry_in;
  logic [DIGIT_W-1:0] b_x;
  logic [DIGIT_W:0]   total;
  logic [DIGIT_W-1:0] s;
  logic               c;
  logic               c_into_msb;
  logic               term;

  assign first_beat = (state_q == S_FIRST);
  assign mode_eff   = first_beat ? sub : mode_q;
  assign carry_in   = first_beat ? sub : carry_q;
  assign b_x        = b ^ {DIGIT_W{mode_eff}};
  assign total      = {1'b0, a} + {1'b0, b_x} + {{DIGIT_W{1'b0}}, carry_in};
  assign s          = total[DIGIT_W-1:0];
  assign c          = total[DIGIT_W];
  // The sum bit is a ^ b ^ carry-in, so the carry into the MSB can be
  // recovered from the MSB bits alone. This holds for any DIGIT_W.
  assign c_into_msb = s[DIGIT_W-1] ^ a[DIGIT_W-1] ^ b_x[DIGIT_W-1];
  assign term       = last | (cnt_q == CNT_LAST);

  // Next state: operand bookkeeping advances only on beats.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    if (vld) begin
      if (first_beat) mode_d = sub;
      if (term) begin
        state_d = S_FIRST;
        carry_d = 1'b0;
        cnt_d   = '0;
      end else begin
        state_d = S_BUSY;
        carry_d = c;
        cnt_d   = cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers and registered result/status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FIRST;
      mode_q    <= 1'b0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      out_vld   <= 1'b0;
      sum       <= '0;
      out_last  <= 1'b0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      len_err   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      out_vld  <= vld;
      if (vld) begin
        sum       <= s;
        out_last  <= term;
        carry_out <= term & c;
        overflow  <= term & (c_into_msb ^ c);
        len_err   <= term & ~last;
      end else begin
        out_last  <= 1'b0;
        carry_out <= 1'b0;
        overflow  <= 1'b0;
        len_err   <= 1'b0;
      end
    end
  end

`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
  logic zacc_q;
  logic zacc_eff;

  // The accumulator is not used on a first beat, so a new operand always
  // starts from "all digits zero so far".
  assign zacc_eff = (first_beat | zacc_q) & (s == '0);

  // Track whether every result digit of the operand has been zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zacc_q <= 1'b1;
      zero   <= 1'b0;
    end else if (vld) begin
      zacc_q <= term ? 1'b1 : zacc_eff;
      zero   <= term & zacc_eff;
    end else begin
      zero   <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_serial_addsub_digit.sv
// Scoreboard bench for serial_addsub_digit (DIGIT_W=4, MAX_BEATS=4).
// Each expected result is computed from the whole operand values with
// integer arithmetic. The monitor then checks the DUT output digit by digit.
module tb_serial_addsub_digit;

  localparam int W  = 4;
  localparam int MB = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         vld = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         sub = 1'b0;
  logic         last = 1'b0;
  logic         out_vld;
  logic [W-1:0] sum;
  logic         out_last;
  logic         carry_out;
  logic         overflow;
  logic         len_err;
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
  logic         zero;
`endif

  serial_addsub_digit #(.DIGIT_W(W), .MAX_BEATS(MB)) dut (
    .clk(clk), .rst(rst), .vld(vld), .a(a), .b(b), .sub(sub), .last(last),
    .out_vld(out_vld), .sum(sum), .out_last(out_last),
    .carry_out(carry_out), .overflow(overflow),
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
    .len_err(len_err), .zero(zero)
`else
    .len_err(len_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sm;
    logic         lst;
    logic         cy;
    logic         ov;
    logic         le;
    logic         z;
    int           cyc;
  } exp_t;

  exp_t         q[$];
  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  logic [W-1:0] prev_sum = '0;

  always @(posedge clk) cyc++;

  // Monitor: pop and compare whenever the DUT presents a digit.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_sum = '0;
    end else if (out_vld) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL spurious_out_vld cyc=%0d sum=%h", cyc, sum);
      end else begin
        e = q.pop_front();
        if (sum !== e.sm || out_last !== e.lst || carry_out !== e.cy ||
            overflow !== e.ov || len_err !== e.le || cyc != e.cyc
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
            || zero !== e.z
`endif
            ) begin
          failures++;
          $display("FAIL digit cyc=%0d got sum=%h last=%b cy=%b ov=%b le=%b exp sum=%h last=%b cy=%b ov=%b le=%b z=%b at cyc=%0d",
                   cyc, sum, out_last, carry_out, overflow, len_err,
                   e.sm, e.lst, e.cy, e.ov, e.le, e.z, e.cyc);
        end
      end
      prev_sum = sum;
    end else begin
      checks++;
      if (out_last !== 1'b0 || carry_out !== 1'b0 || overflow !== 1'b0 ||
          len_err !== 1'b0 || sum !== prev_sum) begin
        failures++;
        $display("FAIL idle_outputs cyc=%0d got sum=%h last=%b cy=%b ov=%b le=%b exp sum=%h and zero flags",
                 cyc, sum, out_last, carry_out, overflow, len_err, prev_sum);
      end
      if (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        checks++;
        failures++;
        $display("FAIL missing_out_vld cyc=%0d out_vld=0 exp sum=%h", cyc, e.sm);
      end
    end
  end

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clk); #1;
      vld  = 1'b0;
      a    = 4'($urandom);
      b    = 4'($urandom);
      sub  = 1'($urandom);
      last = 1'($urandom);
    end
  endtask

  // Drive one operand of n digits (stop early after stop_after beats).
  // The expected digits come from whole-value arithmetic.
  task automatic drive_op(input int n, input logic [15:0] av_i,
                          input logic [15:0] bv_i, input bit sb,
                          input bit nolast, input int stop_after,
                          input int max_idle);
    longint mask, av, bv, beff, r;
    int     nb;
    bit     cy, ov, z, fin;
    exp_t   e;
    nb   = W * n;
    mask = (longint'(1) << nb) - 1;
    av   = longint'(av_i) & mask;
    bv   = longint'(bv_i) & mask;
    beff = sb ? (~bv & mask) : bv;
    r    = av + beff + (sb ? 1 : 0);
    cy   = ((r >> nb) & 1) != 0;
    ov   = (((av >> (nb-1)) & 1) == ((beff >> (nb-1)) & 1)) &&
           (((r >> (nb-1)) & 1) != ((av >> (nb-1)) & 1));
    z    = (r & mask) == 0;
    for (int i = 0; i < stop_after; i++) begin
      idle($urandom_range(0, max_idle));
      @(posedge clk); #1;
      fin  = (i == n-1);
      vld  = 1'b1;
      a    = 4'(av >> (W*i));
      b    = 4'(bv >> (W*i));
      sub  = (i == 0) ? sb : 1'($urandom);
      last = fin && !nolast;
      e.sm  = 4'(r >> (W*i));
      e.lst = fin;
      e.cy  = fin & cy;
      e.ov  = fin & ov;
      e.le  = fin & nolast;
      e.z   = fin & z;
      e.cyc = cyc + 1;
      q.push_back(e);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (out_vld !== 1'b0 || sum !== '0 || out_last !== 1'b0 ||
        carry_out !== 1'b0 || overflow !== 1'b0 || len_err !== 1'b0) begin
      failures++;
      $display("FAIL %s got vld=%b sum=%h last=%b cy=%b ov=%b le=%b exp all 0",
               name, out_vld, sum, out_last, carry_out, overflow, len_err);
    end
  endtask

  initial begin
    int n;
    bit nl;
    #1 rst = 1'b1;
    #1 check_reset_outputs("reset_state");
    #20 rst = 1'b0;

    // add 0x1234 + 0x0FFF -> 0x2233
    drive_op(4, 16'h1234, 16'h0FFF, 1'b0, 1'b0, 4, 0);
    // same operands with idle gaps between beats
    drive_op(4, 16'h1234, 16'h0FFF, 1'b0, 1'b0, 4, 3);
    // 0x05 - 0x07 -> E,F with borrow; 0x07 - 0x07 -> 0,0 with carry
    drive_op(2, 16'h05, 16'h07, 1'b1, 1'b0, 2, 0);
    drive_op(2, 16'h07, 16'h07, 1'b1, 1'b0, 2, 1);
    // signed overflow cases
    drive_op(2, 16'h7F, 16'h01, 1'b0, 1'b0, 2, 0);
    drive_op(2, 16'h80, 16'h80, 1'b0, 1'b0, 2, 0);
    // single-beat operands
    drive_op(1, 16'h8, 16'h8, 1'b0, 1'b0, 1, 0);
    drive_op(1, 16'h3, 16'h5, 1'b1, 1'b0, 1, 0);
    // length error after MAX_BEATS, then the 5th beat is a FIRST beat (sub=1)
    drive_op(4, 16'h0, 16'h0, 1'b0, 1'b1, 4, 0);
    drive_op(1, 16'h0, 16'h0, 1'b1, 1'b0, 1, 0);

    // reset mid-operand: two carry-producing beats, then an async reset
    drive_op(4, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 2, 0);
    idle(1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_reset_mid_op");
    prev_sum = '0;
    #1 rst = 1'b0;
    drive_op(1, 16'h1, 16'h1, 1'b0, 1'b0, 1, 0);

    // randomized operands
    for (int k = 0; k < 300; k++) begin
      n  = $urandom_range(1, MB);
      nl = (n == MB) && ($urandom_range(0, 3) == 0);
      drive_op(n, 16'($urandom), 16'($urandom), 1'($urandom), nl, n, 2);
    end

    idle(2);
    for (int t = 0; t < 20 && q.size() != 0; t++) @(posedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain got pending=%0d exp 0", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
